// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: stereo I2S serializer with a small sample FIFO, generating MCLK/BCLK/LRCLK.
// Latency: a pair accepted at least one Clk before a frame load has its left MSB on sd at that load.
// Backpressure: in_ready = !full, taken from the registered FIFO level; pops happen only at frame loads.
//
// Ports:
//   Clk, Reset          system clock, asynchronous active-high reset
//   in_valid/in_ready   producer handshake for one stereo pair
//   in_left, in_right   two's-complement samples, SAMPLE_W bits each
//   mclk                Clk/4 codec master clock
//   bclk                bit clock, Clk/(2*BCLK_HALF)
//   lrclk               word select (0 = left, 1 = right)
//   sd                  serial data, MSB first, one BCLK after each LRCLK edge, 32-bit slots
//   underrun            one-Clk pulse when a frame load finds the FIFO empty
//   fifo_level          stereo pairs currently buffered
//
// Build option: define I2S_TX_HOLD_LAST_EN to replay the last popped pair on underrun
// instead of sending silence.

// Generic single-clock FIFO used for the sample buffer.
// Latency: one Clk from push to visibility at head_dat; no bypass of an empty FIFO.
// Backpressure: push_rdy is low while full; pop of an empty FIFO is ignored.
module i2s_sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_vld,
  output logic                         push_rdy,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign push_rdy = (level_q != LVL_W'(DEPTH));
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop && (level_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      // DEPTH is a power of two, so the pointers wrap naturally.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module i2s_sample_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_HALF  = 8
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SAMPLE_W-1:0]               in_left,
  input  logic [SAMPLE_W-1:0]               in_right,
  output logic                              mclk,
  output logic                              bclk,
  output logic                              lrclk,
  output logic                              sd,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
  localparam int              PAIR_W  = 2 * SAMPLE_W;
  localparam int              HC_W    = $clog2(BCLK_HALF);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(BCLK_HALF - 1);

  // Left-align a sample in a 32-bit slot, zero-padding the LSBs.
  function automatic logic [31:0] pad_slot(input logic [SAMPLE_W-1:0] s);
    logic [31:0] r;
    r = '0;
    r[31 -: SAMPLE_W] = s;
    return r;
  endfunction

  // Clock generation state
  logic [1:0]      mclk_cnt_q, mclk_cnt_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic            bclk_q, bclk_d;
  // Position within the 64-bit frame; bit 5 is the word select.
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  // Serializer: bit 63 is the bit currently on sd.
  logic [63:0]     frame_q, frame_d;
  logic            underrun_q, underrun_d;

  logic              bclk_tgl;
  logic              bclk_fall;
  logic              frame_load;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [PAIR_W-1:0] head_dat;
  logic [63:0]       head_frame;
  logic [63:0]       starve_frame;

  i2s_sample_fifo #(
    .W     (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat ({in_left, in_right}),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .level    (fifo_level)
  );

  assign bclk_tgl   = (hc_q == HC_LAST);
  assign bclk_fall  = bclk_tgl && bclk_q;
  // Loading on the 0->1 advance puts the left MSB on sd one BCLK after lrclk falls.
  assign frame_load = bclk_fall && (bit_cnt_q == 6'd0);
  // Empty is judged from the registered level, so a push in the load cycle is not bypassed.
  assign fifo_empty = (fifo_level == '0);
  assign fifo_pop   = frame_load && !fifo_empty;
  assign head_frame = {pad_slot(head_dat[PAIR_W-1 -: SAMPLE_W]), pad_slot(head_dat[SAMPLE_W-1:0])};

`ifdef I2S_TX_HOLD_LAST_EN
  // Last pair handed to the serializer; replayed when the producer falls behind.
  logic [PAIR_W-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (fifo_pop) begin
      last_d = head_dat;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

  assign starve_frame = {pad_slot(last_q[PAIR_W-1 -: SAMPLE_W]), pad_slot(last_q[SAMPLE_W-1:0])};
`else
  assign starve_frame = '0;
`endif

  always_comb begin
    mclk_cnt_d = mclk_cnt_q + 2'd1;
    hc_d       = bclk_tgl ? '0 : hc_q + HC_W'(1);
    bclk_d     = bclk_tgl ? ~bclk_q : bclk_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    underrun_d = 1'b0;
    if (bclk_fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      if (frame_load) begin
        if (fifo_empty) begin
          frame_d    = starve_frame;
          underrun_d = 1'b1;
        end else begin
          frame_d = head_frame;
        end
      end else begin
        frame_d = {frame_q[62:0], 1'b0};
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mclk_cnt_q <= '0;
      hc_q       <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      hc_q       <= hc_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  // All pin outputs come straight from flops, so lrclk and sd change on the bclk falling edge.
  assign mclk     = mclk_cnt_q[1];
  assign bclk     = bclk_q;
  assign lrclk    = bit_cnt_q[5];
  assign sd       = frame_q[63];
  assign underrun = underrun_q;
endmodule

// File: tb/tb_i2s_sample_tx.sv
`timescale 1ns/1ps
module tb_i2s_sample_tx;
  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int BH    = 8;
  localparam int FRAME = 128 * BH;
  localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    in_left;
  logic [SW-1:0]    in_right;
  logic             mclk, bclk, lrclk, sd, underrun;
  logic [LVL_W-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  i2s_sample_tx #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH),
    .BCLK_HALF  (BH)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .mclk       (mclk),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sd         (sd),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [31:0] a;
    logic [31:0] b;
    a = '0;
    b = '0;
    a[31 -: SW] = l;
    b[31 -: SW] = r;
    return {a, b};
  endfunction

  // ---------------- scoreboard model (runs on the falling Clk edge) ----------------
  logic [63:0] cur_exp;       // expected frame for the pair currently on in_left/in_right
  logic [63:0] mq[$];         // model FIFO of expected frames
  logic [63:0] sbq[$];        // frames loaded, waiting to appear on the pins
  logic [63:0] last_exp;
  int          up_edge;       // number of the next rising Clk edge since reset release
  bit          exp_ur_pend;
  int          ur_seen;
  int          prev_ld_ur;

  always @(negedge Clk) begin : model
    bit          rdy;
    bit          ld;
    logic [63:0] f;
    if (Reset) begin
      mq.delete();
      sbq.delete();
      last_exp    = '0;
      up_edge     = 0;
      exp_ur_pend = 1'b0;
      ur_seen     = 0;
      prev_ld_ur  = 0;
    end else begin
      up_edge++;
      if (exp_ur_pend) check("underrun_pulse", underrun, 1);
      exp_ur_pend = 1'b0;
      if (underrun) ur_seen++;
      rdy = (mq.size() < DEPTH);
      if (in_valid) begin
        check("in_ready", in_ready, rdy);
        check("fifo_level_hs", fifo_level, mq.size());
      end
      ld = (up_edge >= 2 * BH) && (((up_edge - 2 * BH) % FRAME) == 0);
      if (ld) begin
        check("underrun_count", ur_seen, prev_ld_ur);
        ur_seen = 0;
        if (mq.size() > 0) begin
          f          = mq.pop_front();
          last_exp   = f;
          prev_ld_ur = 0;
        end else begin
          f           = HOLD ? last_exp : 64'h0;
          prev_ld_ur  = 1;
          exp_ur_pend = 1'b1;
        end
        sbq.push_back(f);
      end
      if (in_valid && rdy) mq.push_back(cur_exp);
    end
  end

  // ---------------- pin monitor: samples sd/lrclk as the codec would ----------------
  logic [63:0] cap;
  logic [63:0] lrcap;
  int          nbits;
  logic        prev_bclk;
  logic        prev_lr;
  int          frames_cmp = 0;

  always @(negedge Clk) begin : monitor
    logic [63:0] e;
    if (Reset) begin
      cap       = '0;
      lrcap     = '0;
      nbits     = 0;
      prev_bclk = 1'b0;
      prev_lr   = 1'b0;
    end else begin
      if (bclk && !prev_bclk) begin
        cap   = {cap[62:0], sd};
        lrcap = {lrcap[62:0], lrclk};
        nbits++;
        // lrclk back to 0 marks bit_cnt 0: the previous frame's last bit was just taken.
        if (!lrclk && prev_lr && nbits >= 64) begin
          frames_cmp++;
          check("lrclk_pattern", lrcap, 64'h0000_0001_FFFF_FFFE);
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %h expected no frame", cap);
          end else begin
            e = sbq.pop_front();
            check("frame", cap, e);
          end
        end
        prev_lr = lrclk;
      end
      prev_bclk = bclk;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [SW-1:0]    l;
    logic [SW-1:0]    r;
    logic [63:0]      frame;
    logic [LVL_W-1:0] lvl_push;
    logic [LVL_W-1:0] lvl_load;
  } vec_t;
  vec_t vt[5];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic [63:0] e);
    bit ok;
    ok = 1'b0;
    tick();
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    cur_exp  = e;
    for (int t = 0; t < 4 * FRAME; t++) begin
      @(negedge Clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic reset_dut();
    Reset    = 1'b1;
    in_valid = 1'b0;
    tick(3);
    Reset = 1'b0;
  endtask

  task automatic drive_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    in_left  = l;
    in_right = r;
    cur_exp  = mk_frame(l, r);
  endtask

  initial begin
    int acc;
    int n;
    bit hs;

    vt[0] = '{16'hA5F0, 16'h0F0F, 64'hA5F0_0000_0F0F_0000, 1, 0};
    vt[1] = '{16'hFFFF, 16'h0001, 64'hFFFF_0000_0001_0000, 1, 0};
    vt[2] = '{16'h8001, 16'hFFFE, 64'h8001_0000_FFFE_0000, 1, 0};
    vt[3] = '{16'h0000, 16'hFFFF, 64'h0000_0000_FFFF_0000, 1, 0};
    vt[4] = '{16'h7FFF, 16'h8000, 64'h7FFF_0000_8000_0000, 1, 0};

    Reset    = 1'b1;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    cur_exp  = '0;

    // Reset state
    tick(2);
    check("rst_mclk", mclk, 0);
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sd", sd, 0);
    check("rst_underrun", underrun, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    Reset = 1'b0;

    // Clock start-up after release
    tick(2);
    check("mclk_high_edge2", mclk, 1);
    tick(2);
    check("mclk_low_edge4", mclk, 0);
    tick(3);
    check("bclk_low_edge7", bclk, 0);
    tick(1);
    check("bclk_rise_edge8", bclk, 1);

    // One pair per frame from the table, each pushed a few cycles before its load.
    for (int i = 0; i < 5; i++) begin
      push_pair(vt[i].l, vt[i].r, vt[i].frame);
      check("level_after_push", fifo_level, vt[i].lvl_push);
      tick(7);
      check("level_after_load", fifo_level, vt[i].lvl_load);
      tick(FRAME - 2 - 7);
    end
    // Two starved frames
    tick(2 * FRAME + 32);

    // Backpressure: in_valid held high with incrementing data from release.
    reset_dut();
    acc = 0;
    n   = 0;
    in_valid = 1'b1;
    drive_pair(SW'(16'h1000 + n), SW'(16'h2000 + n));
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      hs = in_ready;
      if (c == 14) begin
        check("bp_in_ready_full", in_ready, 0);
        check("bp_level_full", fifo_level, DEPTH);
      end
      @(posedge Clk);
      #1;
      if (hs) begin
        acc++;
        n++;
        drive_pair(SW'(16'h1000 + n), SW'(16'h2000 + n));
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, DEPTH + 1);
    tick(9 * FRAME + 64);

    // Reset in the right slot with three pairs buffered.
    reset_dut();
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_pair(SW'(16'h3000 + c), SW'(16'h5000 + c));
      tick();
    end
    in_valid = 1'b0;
    tick(641);
    check("mid_lrclk", lrclk, 1);
    check("mid_level", fifo_level, 3);
    Reset = 1'b1;
    #1;
    check("mid_rst_mclk", mclk, 0);
    check("mid_rst_bclk", bclk, 0);
    check("mid_rst_lrclk", lrclk, 0);
    check("mid_rst_sd", sd, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_in_ready", in_ready, 1);
    tick(3);
    Reset = 1'b0;

    // Push landing on the same edge as the first load: not bypassed.
    tick(15);
    in_valid = 1'b1;
    drive_pair(16'h4321, 16'h8765);
    tick();
    in_valid = 1'b0;
    check("coll_underrun", underrun, 1);
    check("coll_level", fifo_level, 1);
    tick(3 * FRAME);

    check("frames_seen", frames_cmp, 19);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
